// File: rtl/alu_operand_stage.sv
// Operand stage: resolves rs1/rs2 through the forwarding network, stalls on in-flight loads,
// and registers op_a/op_b/store_data behind a valid/ready handshake.
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    input  logic [XLEN-1:0]          reg_data_a,
    input  logic [XLEN-1:0]          reg_data_b,
    input  logic [XLEN-1:0]          imm_value,
    input  logic [XLEN-1:0]          pc,
    input  logic                     reg_b_select,
    input  logic                     pc_a_select,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [5*NUM_FWD-1:0]     fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_pending,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          op_a,
    output logic [XLEN-1:0]          op_b,
    output logic [XLEN-1:0]          store_data,
    output logic                     hazard_stall
);

    // Source 0 is rs1, source 1 is rs2; both go through identical resolution logic.
    logic [4:0]      src_addr  [2];
    logic [XLEN-1:0] src_rf    [2];
    logic [XLEN-1:0] src_value [2];
    logic [1:0]      src_hazard;

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;
    assign src_rf[0]   = reg_data_a;
    assign src_rf[1]   = reg_data_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [NUM_FWD-1:0] hit;
            logic [NUM_FWD-1:0] pend;

            for (genvar gj = 0; gj < NUM_FWD; gj++) begin : g_fwd
                logic rd_match;
                assign rd_match  = (fwd_rd[gj*5 +: 5] == src_addr[gi]) && (src_addr[gi] != 5'd0);
                assign hit[gj]   = fwd_valid[gj]   && rd_match;
                assign pend[gj]  = fwd_pending[gj] && rd_match;
            end

            // Walk from oldest to youngest so the lowest index has the final word;
            // a younger valid result hides an older pending load.
            always_comb begin
                src_value[gi]  = src_rf[gi];
                src_hazard[gi] = 1'b0;
                for (int i = NUM_FWD - 1; i >= 0; i--) begin
                    if (hit[i]) begin
                        src_value[gi]  = fwd_data[i*XLEN +: XLEN];
                        src_hazard[gi] = 1'b0;
                    end
                    if (pend[i]) begin
                        src_hazard[gi] = 1'b1;
                    end
                end
                if (src_addr[gi] == 5'd0) begin
                    src_value[gi] = '0;
                end
            end
        end
    endgenerate

    // rs2 always feeds store_data, so it is treated as used regardless of reg_b_select.
    logic rs1_used;
    assign rs1_used     = !pc_a_select;
    assign hazard_stall = in_valid && ((rs1_used && src_hazard[0]) || src_hazard[1]);

    logic            out_valid_reg;
    logic [XLEN-1:0] op_a_reg;
    logic [XLEN-1:0] op_b_reg;
    logic [XLEN-1:0] store_data_reg;
    logic            load;

    assign in_ready = (!out_valid_reg || out_ready) && !hazard_stall;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            store_data_reg <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg  <= 1'b1;
            op_a_reg       <= pc_a_select  ? pc           : src_value[0];
            op_b_reg       <= reg_b_select ? src_value[1] : imm_value;
            store_data_reg <= src_value[1];
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign op_a       = op_a_reg;
    assign op_b       = op_b_reg;
    assign store_data = store_data_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage (XLEN=32, NUM_FWD=2) with hand-computed expectations.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] reg_data_a;
    logic [31:0] reg_data_b;
    logic [31:0] imm_value;
    logic [31:0] pc;
    logic        reg_b_select;
    logic        pc_a_select;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_pending;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data;
    logic        hazard_stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(32), .NUM_FWD(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .reg_data_a   (reg_data_a),
        .reg_data_b   (reg_data_b),
        .imm_value    (imm_value),
        .pc           (pc),
        .reg_b_select (reg_b_select),
        .pc_a_select  (pc_a_select),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .fwd_pending  (fwd_pending),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .store_data   (store_data),
        .hazard_stall (hazard_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0;
        reg_data_a = '0; reg_data_b = '0; imm_value = '0; pc = '0;
        reg_b_select = 1'b0; pc_a_select = 1'b0; fwd_valid = '0; fwd_rd = '0;
        fwd_data = '0; fwd_pending = '0; flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_store_data", store_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #6 rst_n = 1'b1;

        // Immediate path; rs2=0 forces store_data to zero despite reg_data_b
        in_valid = 1'b1; rs1_addr = 5'd5; reg_data_a = 32'h10; rs2_addr = 5'd0;
        reg_data_b = 32'h99; imm_value = 32'h0000_0FFF; reg_b_select = 1'b0;
        step();
        check("imm_out_valid", {31'd0, out_valid}, 32'd1);
        check("imm_op_a", op_a, 32'h10);
        check("imm_op_b", op_b, 32'hFFF);
        check("imm_store_x0", store_data, 32'd0);
        in_valid = 1'b0;
        step();
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Forward priority, back-to-back instructions
        in_valid = 1'b1; rs1_addr = 5'd2; reg_data_a = 32'h20; rs2_addr = 5'd7;
        reg_data_b = 32'h1; reg_b_select = 1'b1; fwd_valid = 2'b11;
        fwd_rd = {5'd7, 5'd7}; fwd_data = {32'hBB, 32'hAA};
        step();
        check("fwd_op_a", op_a, 32'h20);
        check("fwd_op_b", op_b, 32'hAA);
        check("fwd_store", store_data, 32'hAA);
        fwd_valid = 2'b10;
        step();
        check("fwd1_out_valid", {31'd0, out_valid}, 32'd1);
        check("fwd1_op_b", op_b, 32'hBB);
        check("fwd1_store", store_data, 32'hBB);
        fwd_valid = 2'b00; pc_a_select = 1'b1; pc = 32'h1000;
        step();
        check("pc_op_a", op_a, 32'h1000);
        check("rf_op_b", op_b, 32'h1);
        check("tput_out_valid", {31'd0, out_valid}, 32'd1);

        // x0 guard
        pc_a_select = 1'b0; rs1_addr = 5'd0; reg_data_a = 32'h1234;
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFFFF};
        step();
        check("x0_op_a", op_a, 32'd0);
        check("x0_op_b", op_b, 32'h1);

        // Hazard qualifiers, probed combinationally within one cycle
        rs1_addr = 5'd3; pc_a_select = 1'b1; rs2_addr = 5'd0; reg_b_select = 1'b0;
        fwd_valid = 2'b00; fwd_pending = 2'b10; fwd_rd = {5'd3, 5'd0};
        #1 check("haz_rs1_unused", {31'd0, hazard_stall}, 32'd0);
        rs2_addr = 5'd3;
        #1 check("haz_rs2_store", {31'd0, hazard_stall}, 32'd1);
        fwd_valid = 2'b01; fwd_rd = {5'd3, 5'd3}; fwd_data = {32'h0, 32'h77};
        #1 check("haz_younger_valid", {31'd0, hazard_stall}, 32'd0);
        in_valid = 1'b0;
        step();
        check("probe_out_valid", {31'd0, out_valid}, 32'd0);

        // Load-use stall: two stalled cycles then release
        in_valid = 1'b1; rs1_addr = 5'd3; pc_a_select = 1'b0; rs2_addr = 5'd0;
        reg_b_select = 1'b0; imm_value = 32'h4; fwd_valid = 2'b00;
        fwd_pending = 2'b10; fwd_rd = {5'd3, 5'd0}; fwd_data = '0;
        #1;
        check("lu1_stall", {31'd0, hazard_stall}, 32'd1);
        check("lu1_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("lu2_out_valid", {31'd0, out_valid}, 32'd0);
        check("lu2_stall", {31'd0, hazard_stall}, 32'd1);
        check("lu2_in_ready", {31'd0, in_ready}, 32'd0);
        fwd_pending = 2'b00; fwd_valid = 2'b10; fwd_data = {32'h55, 32'h0};
        #1;
        check("lu_release_stall", {31'd0, hazard_stall}, 32'd0);
        check("lu_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("lu_out_valid", {31'd0, out_valid}, 32'd1);
        check("lu_op_a", op_a, 32'h55);
        check("lu_op_b", op_b, 32'h4);
        in_valid = 1'b0; fwd_valid = 2'b00;
        step();
        check("lu_pulse_end", {31'd0, out_valid}, 32'd0);

        // Backpressure then flush
        in_valid = 1'b1; rs1_addr = 5'd1; reg_data_a = 32'hA1; imm_value = 32'hB2;
        out_ready = 1'b1;
        step();
        check("bp_load_op_a", op_a, 32'hA1);
        out_ready = 1'b0; reg_data_a = 32'hC3; imm_value = 32'hD4;
        #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_op_a_hold", op_a, 32'hA1);
            check("bp_op_b_hold", op_b, 32'hB2);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        flush = 1'b1;
        step();
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1; reg_data_a = 32'hE5;
        step();
        check("flush_block_valid", {31'd0, out_valid}, 32'd0);
        check("flush_block_op_a", op_a, 32'hA1);
        flush = 1'b0; in_valid = 1'b0;

        // Asynchronous reset mid-cycle, then acceptance on the first edge after release
        in_valid = 1'b1; reg_data_a = 32'h66; imm_value = 32'h77;
        rs2_addr = 5'd9; reg_data_b = 32'h88;
        step();
        check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        check("ar_pre_store", store_data, 32'h88);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_op_a", op_a, 32'd0);
        check("ar_op_b", op_b, 32'd0);
        check("ar_store", store_data, 32'd0);
        in_valid = 1'b1; reg_data_a = 32'h5A;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_first_accept", {31'd0, out_valid}, 32'd1);
        check("ar_first_op_a", op_a, 32'h5A);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter XLEN, default 32: operand and data width in bits.
REQ-002 Parameter NUM_FWD, default 2: number of forwarding sources; index 0 is the youngest source and has the highest priority.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  decode presents a valid instruction.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 rs1_addr, rs2_addr  input  5 each  source register indices.
REQ-008 reg_data_a, reg_data_b  input  XLEN each  register-file read data.
REQ-009 imm_value  input  XLEN  decoded immediate.
REQ-010 pc  input  XLEN  instruction address.
REQ-011 reg_b_select  input  1  selects operand B source: 1 = resolved rs2 value, 0 = imm_value.
REQ-012 pc_a_select  input  1  selects operand A source: 1 = pc, 0 = resolved rs1 value.
REQ-013 fwd_valid  input  NUM_FWD  per-source result valid.
REQ-014 fwd_rd  input  5*NUM_FWD  per-source destination index.
REQ-015 fwd_data  input  XLEN*NUM_FWD  per-source result.
REQ-016 fwd_pending  input  NUM_FWD  per-source: rd is known but data is not yet available (load in flight).
REQ-017 flush  input  1  discard the held and incoming instruction.
REQ-018 out_valid  output  1  op_a, op_b and store_data are valid.
REQ-019 out_ready  input  1  execute stage accepts the output.
REQ-020 op_a, op_b, store_data  output  XLEN each  registered ALU operands and store data.
REQ-021 hazard_stall  output  1  combinational; high while an incoming instruction waits on a pending source.

Function
REQ-022 Resolution for rs1 and rs2 independently:
- take the lowest index i where fwd_valid[i] is high and fwd_rd[i] equals the source index and the source index is non-zero;
- otherwise use the register-file data.
REQ-023 Source index 0 SHALL always resolve to zero, regardless of register data or forwarding inputs.
REQ-024 hazard_stall SHALL be high when in_valid is high and either used source matches a non-zero fwd_rd[j] with fwd_pending[j] high, and no lower-index valid match exists for that source.
- rs1 counts as used only when pc_a_select is 0.
- rs2 counts as used only when reg_b_select is 1 or the instruction is a store.
- Because store_data always carries rs2, rs2 SHALL always be treated as used.
REQ-025 in_ready SHALL equal (!out_valid || out_ready) && !hazard_stall.
REQ-026 The stage SHALL load its output registers when in_valid && in_ready.
- op_a = pc_a_select ? pc : resolved rs1.
- op_b = reg_b_select ? resolved rs2 : imm_value.
- store_data = resolved rs2.
- out_valid is set to 1.
REQ-027 When out_valid && out_ready and no new load occurs, out_valid SHALL clear at the next edge.
REQ-028 While out_valid && !out_ready, op_a, op_b and store_data SHALL hold their values.
REQ-029 Latency SHALL be one cycle from acceptance to out_valid, with full throughput of one instruction per cycle when out_ready is held high.
REQ-030 flush SHALL clear out_valid at the next edge and block any load in that cycle; flush has priority over load.
REQ-031 Each cycle's pending-hazard check SHALL be re-evaluated; the stall releases in the cycle fwd_pending drops and fwd_valid rises.

Reset
REQ-032 While rst_n is low: out_valid = 0, and op_a, op_b, store_data = 0.
REQ-033 Reset assertion mid-transfer SHALL drop out_valid immediately, without waiting for a clock edge.
REQ-034 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-035 Immediate path:
- Stimulus: reg_b_select=0, imm=0x0000_0FFF, rs1=5, reg_data_a=0x10, no forwarding, out_ready=1.
- Required: next cycle op_a=0x10, op_b=0xFFF, out_valid=1.
REQ-036 Forward priority:
- Stimulus: rs2=7, reg_data_b=1, fwd_valid=2'b11, fwd_rd={7,7}, fwd_data={0xBB,0xAA} (index 0 = 0xAA), reg_b_select=1.
- Required: op_b=0xAA and store_data=0xAA.
REQ-037 x0 guard:
- Stimulus: rs1=0, reg_data_a=0x1234, fwd_valid[0]=1, fwd_rd[0]=0, fwd_data[0]=0xFFFF.
- Required: op_a=0.
REQ-038 Load-use stall:
- Stimulus: rs1=3, fwd_pending[1]=1, fwd_rd[1]=3 for 2 cycles, then fwd_valid[1]=1, fwd_data[1]=0x55.
- Required: hazard_stall=1 and in_ready=0 for 2 cycles, then op_a=0x55 with one out_valid pulse.
REQ-039 Backpressure and flush:
- Stimulus: hold out_ready=0 for 3 cycles with a new in_valid.
- Required: outputs stable and in_ready=0.
- Stimulus: then assert flush.
- Required: out_valid=0 next cycle and the incoming instruction is dropped.
REQ-040 Async reset:
- Stimulus: assert rst_n=0 mid-cycle while out_valid=1.
- Required: out_valid=0 and all operands 0 before the next edge.
